// File: rtl/line_follower_pkg.sv
// Shared types for the line follower: FSM state encoding, steering direction and duty clamp.
// Pure definitions; no latency, no flow control.
package line_follower_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FOLLOW = 3'd1,
      ST_SEARCH = 3'd2,
      ST_STOP   = 3'd3
   } state_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   // Clamp a signed duty request into 0..max_val so large errors saturate instead of wrapping.
   function automatic int sat_duty(input int val, input int max_val);
      if (val < 0) begin
         return 0;
      end else if (val > max_val) begin
         return max_val;
      end else begin
         return val;
      end
   endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM, period 2^DUTY_W cycles; duty is shadow-loaded at counter wrap so edges never glitch.
// Latency: a new duty takes effect at the next wrap; no backpressure, duty input is always accepted.
module pwm_gen #(
   parameter int DUTY_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DUTY_W-1:0] duty,
   output logic              pwm
);

   logic [DUTY_W-1:0] cnt;
   logic [DUTY_W-1:0] shadow;
   logic [DUTY_W-1:0] cnt_nxt;
   logic [DUTY_W-1:0] shadow_nxt;

   assign cnt_nxt    = cnt + 1'b1;
   assign shadow_nxt = (cnt_nxt == '0) ? duty : shadow;

   // pwm is registered against the next counter/shadow pair, so it always equals (cnt < shadow).
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         shadow <= '0;
         pwm    <= 1'b0;
      end else begin
         cnt    <= cnt_nxt;
         shadow <= shadow_nxt;
         pwm    <= (cnt_nxt < shadow_nxt);
      end
   end

endmodule

// File: rtl/line_follower_ctrl.sv
// Line follower: debounced sensor bar -> signed line error -> follow/search/stop FSM -> motor duties and PWM.
// Latency: duties change DEBOUNCE_CYCLES+1 edges after a new sensor value is first sampled; no backpressure.
module line_follower_ctrl
   import line_follower_pkg::*;
#(
   parameter int NUM_SENSORS     = 5,
   parameter int DUTY_W          = 8,
   parameter int BASE_DUTY       = 160,
   parameter int K_GAIN          = 24,
   parameter int SEARCH_DUTY     = 96,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int LOST_TIMEOUT    = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [NUM_SENSORS-1:0] ir_sensor_data,
   output logic                   pwm_signal_left,
   output logic                   pwm_signal_right,
   output logic [DUTY_W-1:0]      control_signal_left,
   output logic [DUTY_W-1:0]      control_signal_right,
   output logic [2:0]             state_o,
   output logic                   line_lost
);

   localparam int CALC_W   = DUTY_W + $clog2(NUM_SENSORS) + 2;
   localparam int DUTY_MAX = (1 << DUTY_W) - 1;
   localparam int DBC_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TMO_W    = $clog2(LOST_TIMEOUT + 1);

   localparam logic [DBC_W-1:0]         DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMO_W-1:0]         TMO_LAST = TMO_W'(LOST_TIMEOUT - 1);
   localparam logic signed [CALC_W-1:0] BASE_S   = CALC_W'(BASE_DUTY);
   localparam logic signed [CALC_W-1:0] GAIN_S   = CALC_W'(K_GAIN);
   localparam logic [DUTY_W-1:0]        SRCH_D   = DUTY_W'(SEARCH_DUTY);

   logic [NUM_SENSORS-1:0]   samp;
   logic [NUM_SENSORS-1:0]   filt;
   logic [DBC_W-1:0]         dbc;
   logic                     filt_nz;
   int                       lo;
   int                       hi;
   logic signed [CALC_W-1:0] err;
   logic signed [CALC_W-1:0] adj;
   logic signed [CALC_W-1:0] left_raw;
   logic signed [CALC_W-1:0] right_raw;
   logic [DUTY_W-1:0]        fol_l;
   logic [DUTY_W-1:0]        fol_r;
   logic [DUTY_W-1:0]        srch_l;
   logic [DUTY_W-1:0]        srch_r;
   logic                     last_dir;
   logic                     dir_nxt;
   state_t                   state;
   logic [TMO_W-1:0]         tcnt;

   // dbc saturates at DBC_LAST, which therefore means "samp held for DEBOUNCE_CYCLES edges".
   always_ff @(posedge clk) begin
      if (reset) begin
         samp <= '0;
         filt <= '0;
         dbc  <= '0;
      end else begin
         samp <= ir_sensor_data;
         if (dbc == DBC_LAST) begin
            filt <= samp;
         end
         if (ir_sensor_data != samp) begin
            dbc <= '0;
         end else if (dbc != DBC_LAST) begin
            dbc <= dbc + 1'b1;
         end
      end
   end

   assign filt_nz = |filt;

   always_comb begin
      lo = 0;
      hi = 0;
      for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
         if (filt[i]) lo = i;
      end
      for (int i = 0; i < NUM_SENSORS; i++) begin
         if (filt[i]) hi = i;
      end
   end

   // Midpoint of the outermost active sensors, doubled so it stays integral; negative = line on the left.
   assign err       = CALC_W'(lo + hi - (NUM_SENSORS - 1));
   assign adj       = GAIN_S * err;
   assign left_raw  = BASE_S + adj;
   assign right_raw = BASE_S - adj;
   assign fol_l     = DUTY_W'(sat_duty(int'(left_raw), DUTY_MAX));
   assign fol_r     = DUTY_W'(sat_duty(int'(right_raw), DUTY_MAX));

   always_comb begin
      dir_nxt = last_dir;
      if (state == ST_FOLLOW && filt_nz) begin
         if (err < 0) begin
            dir_nxt = DIR_LEFT;
         end else if (err > 0) begin
            dir_nxt = DIR_RIGHT;
         end
      end
   end

   // Pivot toward the side the line was last seen on: the inner wheel stops.
   assign srch_l = (dir_nxt == DIR_LEFT) ? '0 : SRCH_D;
   assign srch_r = (dir_nxt == DIR_LEFT) ? SRCH_D : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state                <= ST_IDLE;
         tcnt                 <= '0;
         last_dir             <= DIR_LEFT;
         control_signal_left  <= '0;
         control_signal_right <= '0;
         line_lost            <= 1'b0;
      end else begin
         last_dir <= dir_nxt;
         if (!enable) begin
            state                <= ST_IDLE;
            control_signal_left  <= '0;
            control_signal_right <= '0;
            line_lost            <= 1'b0;
         end else begin
            case (state)
               ST_IDLE, ST_FOLLOW: begin
                  if (filt_nz) begin
                     state                <= ST_FOLLOW;
                     control_signal_left  <= fol_l;
                     control_signal_right <= fol_r;
                     line_lost            <= 1'b0;
                  end else begin
                     state                <= ST_SEARCH;
                     tcnt                 <= '0;
                     control_signal_left  <= srch_l;
                     control_signal_right <= srch_r;
                     line_lost            <= 1'b1;
                  end
               end
               ST_SEARCH: begin
                  // Reacquiring the line outranks the timeout on the same edge.
                  if (filt_nz) begin
                     state                <= ST_FOLLOW;
                     control_signal_left  <= fol_l;
                     control_signal_right <= fol_r;
                     line_lost            <= 1'b0;
                  end else if (tcnt == TMO_LAST) begin
                     state                <= ST_STOP;
                     control_signal_left  <= '0;
                     control_signal_right <= '0;
                     line_lost            <= 1'b1;
                  end else begin
                     tcnt                 <= tcnt + 1'b1;
                     control_signal_left  <= srch_l;
                     control_signal_right <= srch_r;
                     line_lost            <= 1'b1;
                  end
               end
               ST_STOP: begin
                  control_signal_left  <= '0;
                  control_signal_right <= '0;
                  line_lost            <= 1'b1;
               end
               default: begin
                  state                <= ST_IDLE;
                  control_signal_left  <= '0;
                  control_signal_right <= '0;
                  line_lost            <= 1'b0;
               end
            endcase
         end
      end
   end

   assign state_o = state;

   pwm_gen #(
      .DUTY_W (DUTY_W)
   ) u_pwm_left (
      .clk   (clk),
      .reset (reset),
      .duty  (control_signal_left),
      .pwm   (pwm_signal_left)
   );

   pwm_gen #(
      .DUTY_W (DUTY_W)
   ) u_pwm_right (
      .clk   (clk),
      .reset (reset),
      .duty  (control_signal_right),
      .pwm   (pwm_signal_right)
   );

endmodule

// File: tb/tb_line_follower_ctrl.sv
// Bench for line_follower_ctrl: directed scenarios plus random sensor/enable/reset traffic,
// every cycle compared against a behavioural model of the controller.
module tb_line_follower_ctrl;

   localparam int N      = 5;
   localparam int D      = 4;
   localparam int TMO    = 64;
   localparam int BASE   = 160;
   localparam int GAIN   = 24;
   localparam int SRCH   = 96;
   localparam int PMAX   = 255;
   localparam int PERIOD = 256;

   localparam int S_IDLE   = 0;
   localparam int S_FOLLOW = 1;
   localparam int S_SEARCH = 2;
   localparam int S_STOP   = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         enable = 1'b0;
   logic [N-1:0] ir = '0;
   logic         pwm_l;
   logic         pwm_r;
   logic [7:0]   ctl_l;
   logic [7:0]   ctl_r;
   logic [2:0]   st;
   logic         lost;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   line_follower_ctrl dut (
      .clk                  (clk),
      .reset                (reset),
      .enable               (enable),
      .ir_sensor_data       (ir),
      .pwm_signal_left      (pwm_l),
      .pwm_signal_right     (pwm_r),
      .control_signal_left  (ctl_l),
      .control_signal_right (ctl_r),
      .state_o              (st),
      .line_lost            (lost)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- reference model ----------------
   int           m_state = 0;
   int           m_l = 0;
   int           m_r = 0;
   int           m_lost = 0;
   int           m_dir = 0;
   int           m_srch_edges = 0;
   int           m_pc = 0;
   int           m_sh_l = 0;
   int           m_sh_r = 0;
   logic [N-1:0] m_filt = '0;
   logic [N-1:0] m_hist[$];
   int           prev_l, prev_r, err, nxt;
   bit           nz, stable;

   function automatic int line_err(input logic [N-1:0] v);
      int first, last;
      first = -1;
      last  = 0;
      for (int i = 0; i < N; i++) begin
         if (v[i]) begin
            if (first < 0) first = i;
            last = i;
         end
      end
      return first + last - (N - 1);
   endfunction

   function automatic int clampd(input int v);
      return (v < 0) ? 0 : (v > PMAX) ? PMAX : v;
   endfunction

   always @(posedge clk) begin
      prev_l = m_l;
      prev_r = m_r;
      if (reset) begin
         m_state = S_IDLE; m_l = 0; m_r = 0; m_lost = 0; m_dir = 0; m_srch_edges = 0;
         m_filt = '0;
         m_hist.delete();
         m_hist.push_back('0);
         m_pc = 0; m_sh_l = 0; m_sh_r = 0;
      end else begin
         nz  = (m_filt != '0);
         err = nz ? line_err(m_filt) : 0;
         if (m_state == S_FOLLOW && nz && err != 0) m_dir = (err < 0) ? 0 : 1;
         if (!enable)                                             nxt = S_IDLE;
         else if (m_state == S_STOP)                              nxt = S_STOP;
         else if (nz)                                             nxt = S_FOLLOW;
         else if (m_state == S_SEARCH && m_srch_edges + 1 >= TMO) nxt = S_STOP;
         else                                                     nxt = S_SEARCH;
         if (nxt == S_SEARCH) m_srch_edges = (m_state == S_SEARCH) ? m_srch_edges + 1 : 0;
         m_state = nxt;
         if (nxt == S_FOLLOW) begin
            m_l = clampd(BASE + GAIN * err);
            m_r = clampd(BASE - GAIN * err);
         end else if (nxt == S_SEARCH) begin
            m_l = (m_dir == 0) ? 0 : SRCH;
            m_r = (m_dir == 0) ? SRCH : 0;
         end else begin
            m_l = 0;
            m_r = 0;
         end
         m_lost = (nxt == S_SEARCH || nxt == S_STOP) ? 1 : 0;
         // filtered vector follows the samples once the last D of them agree
         stable = (m_hist.size() == D);
         foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) stable = 1'b0;
         if (stable) m_filt = m_hist[0];
         m_hist.push_back(ir);
         if (m_hist.size() > D) void'(m_hist.pop_front());
         m_pc = (m_pc + 1) % PERIOD;
         if (m_pc == 0) begin
            m_sh_l = prev_l;
            m_sh_r = prev_r;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_state", int'(st), m_state);
         check("m_ctl_l", int'(ctl_l), m_l);
         check("m_ctl_r", int'(ctl_r), m_r);
         check("m_lost",  int'(lost), m_lost);
         check("m_pwm_l", int'(pwm_l), (m_pc < m_sh_l) ? 1 : 0);
         check("m_pwm_r", int'(pwm_r), (m_pc < m_sh_r) ? 1 : 0);
      end
   end

   // ---------------- stimulus ----------------
   int hl, hr;

   initial begin
      reset = 1'b1; enable = 1'b1; ir = 5'b10110;
      cycles(3);
      chk_en = 1'b1;
      check("rst_state", int'(st), 0);
      check("rst_ctl_l", int'(ctl_l), 0);
      check("rst_ctl_r", int'(ctl_r), 0);
      check("rst_pwm_l", int'(pwm_l), 0);
      check("rst_lost",  int'(lost), 0);

      reset = 1'b0; ir = 5'b00100;
      cycles(6);
      check("start_state", int'(st), 1);
      check("start_l", int'(ctl_l), 160);
      check("start_r", int'(ctl_r), 160);

      ir = 5'b00001; cycles(8);
      check("far_left_l", int'(ctl_l), 64);
      check("far_left_r", int'(ctl_r), 255);
      ir = 5'b01000; cycles(8);
      check("right2_l", int'(ctl_l), 208);
      check("right2_r", int'(ctl_r), 112);

      ir = 5'b00100; cycles(8);
      ir = 5'b10000; cycles(3);
      ir = 5'b00100; cycles(10);
      check("glitch_l", int'(ctl_l), 160);
      check("glitch_r", int'(ctl_r), 160);
      ir = 5'b10000; cycles(5);
      check("pre_upd_l", int'(ctl_l), 160);
      cycles(1);
      check("upd_l", int'(ctl_l), 255);
      check("upd_r", int'(ctl_r), 64);

      ir = 5'b00001; cycles(8);
      ir = 5'b00000; cycles(6);
      check("srch_state", int'(st), 2);
      check("srch_l", int'(ctl_l), 0);
      check("srch_r", int'(ctl_r), 96);
      check("srch_lost", int'(lost), 1);
      cycles(63);
      check("pre_stop", int'(st), 2);
      cycles(1);
      check("stop_state", int'(st), 3);
      check("stop_l", int'(ctl_l), 0);
      check("stop_r", int'(ctl_r), 0);
      check("stop_lost", int'(lost), 1);
      ir = 5'b00100; cycles(10);
      check("stop_hold", int'(st), 3);
      enable = 1'b0; cycles(1);
      check("idle_state", int'(st), 0);
      check("idle_lost", int'(lost), 0);

      enable = 1'b1; ir = 5'b00001; cycles(300);
      hl = 0; hr = 0;
      for (int i = 0; i < PERIOD; i++) begin
         cycles(1);
         if (pwm_l) hl++;
         if (pwm_r) hr++;
      end
      check("pwm64_high", hl, 64);
      check("pwm255_high", hr, 255);
      ir = 5'b01000; cycles(300);

      ir = 5'b00000; cycles(12);
      check("srch2_state", int'(st), 2);
      reset = 1'b1; cycles(1);
      check("midrst_state", int'(st), 0);
      check("midrst_pwm_l", int'(pwm_l), 0);
      check("midrst_pwm_r", int'(pwm_r), 0);
      check("midrst_ctl_l", int'(ctl_l), 0);
      check("midrst_ctl_r", int'(ctl_r), 0);
      reset = 1'b0;

      for (int it = 0; it < 1500; it++) begin
         int           sel;
         int           hold;
         logic [N-1:0] v;
         sel = int'($urandom_range(0, 9));
         case (sel)
            0:       v = '0;
            1:       v = '1;
            2, 3:    v = N'(1) << $urandom_range(0, N - 1);
            default: v = N'($urandom_range(0, 31));
         endcase
         hold = (v == '0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(60, 90))
                                                       : int'($urandom_range(1, 12));
         ir     = v;
         enable = ($urandom_range(0, 19) != 0);
         reset  = ($urandom_range(0, 49) == 0);
         cycles(1);
         reset = 1'b0;
         cycles(hold);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
